// File: rtl/clkout_div_pkg.sv
`default_nettype none
// ============================================================================
// clkout_div_pkg : shared types and the config legality check
// Rev 1.0
// ============================================================================
package clkout_div_pkg;

  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [0:0] {
    ST_DELAY = 1'b0,
    ST_RUN   = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] div;
    logic [DEF_CNT_W-1:0] high;
    logic [DEF_CNT_W-1:0] phase;
  } ch_cfg_t;

  // Operands arrive zero-extended, so every comparison is unsigned.
  function automatic logic cfg_legal(input logic [31:0] ch,
                                     input logic [31:0] num_ch,
                                     input logic [31:0] div,
                                     input logic [31:0] high);
    return (ch < num_ch) && (div >= 32'd2) && (high != 32'd0) && (high < div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clkout_div_ch.sv
`default_nettype none
// ============================================================================
// clkout_div_ch : one divider channel with phase delay and period-aligned reconfig
// Rev 1.0
// ============================================================================
module clkout_div_ch
  import clkout_div_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  input  logic [CNT_W-1:0] wr_high_i,
  input  logic [CNT_W-1:0] wr_phase_i,
  output logic             pend_o,
  output logic             apply_o,
  output logic             clkout_o
);

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } cfg_t;

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cfg_t             act_q, act_d;
  cfg_t             pnd_q, pnd_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             wrap;
  logic             start;

  assign wrap  = (state_q == ST_RUN) && (cnt_q == act_q.div - CNT_W'(1));
  assign start = (state_q == ST_DELAY) && (dly_q == act_q.phase);

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pnd_d   = pnd_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    apply_o = 1'b0;
    if (sync_i) begin
      if (pend_q) act_d = pnd_q;
      pend_d  = 1'b0;
      state_d = ST_DELAY;
      dly_d   = '0;
      cnt_d   = '0;
      clk_d   = 1'b0;
    end else if (wrap || start) begin
      // Period boundary: the only point where new div/high may take over.
      state_d = ST_RUN;
      cnt_d   = '0;
      if (pend_q) begin
        act_d   = pnd_q;
        pend_d  = 1'b0;
        apply_o = 1'b1;
      end
      clk_d = (act_d.high != '0);
    end else if (state_q == ST_DELAY) begin
      dly_d = dly_q + CNT_W'(1);
      clk_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      clk_d = (cnt_d < act_q.high);
    end
    if (wr_i) begin
      pnd_d.div   = wr_div_i;
      pnd_d.high  = wr_high_i;
      pnd_d.phase = wr_phase_i;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_DELAY;
      dly_q        <= '0;
      cnt_q        <= '0;
      act_q.div    <= CNT_W'(DEF_DIV);
      act_q.high   <= CNT_W'(DEF_DIV / 2);
      act_q.phase  <= '0;
      pnd_q        <= '0;
      pend_q       <= 1'b0;
      clk_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pnd_q   <= pnd_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
    end
  end

  assign pend_o   = pend_q;
  assign clkout_o = clk_q;

endmodule
`default_nettype wire

// File: rtl/clkout_div_bank.sv
`default_nettype none
// ============================================================================
// clkout_div_bank : VCO-rate output-divider bank with run-time config and lock
// Rev 1.0
// ============================================================================
module clkout_div_bank
  import clkout_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 7,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEF_DIV     = 4,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clkout,
  output logic              LOCKED
);

  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] apply;
  logic              legal;
  logic              accept;
  logic              cfg_err_q, cfg_err_d;
  logic [LOCK_W-1:0] lock_q, lock_d;

  // Out-of-range channels never match, so they stay ready and get flagged.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (cfg_ch == 4'(i) && pend[i]) cfg_ready = 1'b0;
    end
  end

  assign legal     = cfg_legal(32'(cfg_ch), 32'(NUM_CH), 32'(cfg_div), 32'(cfg_high));
  assign accept    = cfg_valid & cfg_ready;
  assign cfg_err_d = accept & ~legal;

  always_comb begin
    lock_d = lock_q;
    if (sync || (|apply)) begin
      lock_d = '0;
    end else if (lock_q != LOCK_W'(LOCK_CYCLES)) begin
      lock_d = lock_q + LOCK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cfg_err_q <= 1'b0;
      lock_q    <= '0;
    end else begin
      cfg_err_q <= cfg_err_d;
      lock_q    <= lock_d;
    end
  end

  assign cfg_err = cfg_err_q;
  assign LOCKED  = (lock_q == LOCK_W'(LOCK_CYCLES));

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    logic wr;
    assign wr = accept & legal & (cfg_ch == 4'(i));

    clkout_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk        (clk),
      .rst        (RST),
      .sync_i     (sync),
      .wr_i       (wr),
      .wr_div_i   (cfg_div),
      .wr_high_i  (cfg_high),
      .wr_phase_i (cfg_phase),
      .pend_o     (pend[i]),
      .apply_o    (apply[i]),
      .clkout_o   (clkout[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clkout_div_bank.sv
`default_nettype none
// ============================================================================
// tb_clkout_div_bank : directed self-checking bench for clkout_div_bank
// Rev 1.0
// ============================================================================
module tb_clkout_div_bank;

  localparam int NUM_CH = 7;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              RST;
  logic              sync;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [3:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_high;
  logic [CNT_W-1:0]  cfg_phase;
  logic              cfg_err;
  logic [NUM_CH-1:0] clkout;
  logic              LOCKED;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int e_start [NUM_CH];
  int e_div   [NUM_CH];
  int e_high  [NUM_CH];

  always #5 clk = ~clk;

  clkout_div_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEF_DIV     (4),
    .LOCK_CYCLES (64)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .cfg_err   (cfg_err),
    .clkout    (clkout),
    .LOCKED    (LOCKED)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Ideal divided clock: high for 'high' edges out of every 'div', from edge 'start'.
  function automatic logic [NUM_CH-1:0] exp_out(input int n);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (n >= e_start[c] && ((n - e_start[c]) % e_div[c]) < e_high[c]) v[c] = 1'b1;
    end
    return v;
  endfunction

  task automatic set_ch(input int c, input int start, input int dv, input int hi);
    e_start[c] = start;
    e_div[c]   = dv;
    e_high[c]  = hi;
  endtask

  task automatic set_all(input int start, input int dv, input int hi);
    for (int c = 0; c < NUM_CH; c++) set_ch(c, start, dv, hi);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_chk(input int upto, input string tag);
    while (cyc < upto) begin
      step();
      chk(tag, 32'(clkout), 32'(exp_out(cyc)));
    end
  endtask

  task automatic drive(input int ch, input int dv, input int hi, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = 4'(ch);
    cfg_div   = CNT_W'(dv);
    cfg_high  = CNT_W'(hi);
    cfg_phase = CNT_W'(ph);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; sync = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_high = '0; cfg_phase = '0;
    #1;
    chk("rst_clkout", 32'(clkout), 32'd0);
    chk("rst_locked", 32'(LOCKED), 32'd0);
    chk("rst_ready",  32'(cfg_ready), 32'd1);
    chk("rst_err",    32'(cfg_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    cyc = 0;

    // Defaults: 1,1,0,0 from edge 1, lock at edge 64.
    set_all(1, 4, 2);
    run_chk(63, "dflt_out");
    chk("lock_63", 32'(LOCKED), 32'd0);
    run_chk(64, "dflt_out");
    chk("lock_64", 32'(LOCKED), 32'd1);
    run_chk(65, "dflt_out");

    // ch2 -> div 5 / high 1, applied at the wrap on edge 69.
    drive(2, 5, 1, 0);
    chk("ch2_ready_idle", 32'(cfg_ready), 32'd1);
    run_chk(66, "ch2_wr");
    cfg_valid = 1'b0;
    chk("ch2_ready_pend", 32'(cfg_ready), 32'd0);
    chk("ch2_lock_hold", 32'(LOCKED), 32'd1);
    run_chk(68, "ch2_old");
    set_ch(2, 69, 5, 1);
    run_chk(69, "ch2_new");
    chk("ch2_ready_applied", 32'(cfg_ready), 32'd1);
    chk("ch2_lock_drop", 32'(LOCKED), 32'd0);
    run_chk(132, "ch2_run");
    chk("relock_132", 32'(LOCKED), 32'd0);
    run_chk(133, "ch2_run");
    chk("relock_133", 32'(LOCKED), 32'd1);

    // ch1 phase 3, then sync on edge 135.
    drive(1, 4, 2, 3);
    run_chk(134, "ph_wr");
    cfg_valid = 1'b0;
    sync = 1'b1;
    chk("ch1_ready_pend", 32'(cfg_ready), 32'd0);
    step();
    sync = 1'b0;
    chk("sync_out_low", 32'(clkout), 32'd0);
    chk("sync_pend_clr", 32'(cfg_ready), 32'd1);
    chk("sync_lock_drop", 32'(LOCKED), 32'd0);
    set_all(136, 4, 2);
    set_ch(1, 139, 4, 2);
    set_ch(2, 136, 5, 1);
    run_chk(145, "post_sync");

    // Illegal requests: each accepted, dropped, one-cycle cfg_err.
    drive(0, 1, 1, 0);
    run_chk(cyc + 1, "ill_div");
    cfg_valid = 1'b0;
    chk("err_div1", 32'(cfg_err), 32'd1);
    run_chk(cyc + 1, "ill_div");
    chk("err_div1_clr", 32'(cfg_err), 32'd0);
    chk("ill_ch0_ready", 32'(cfg_ready), 32'd1);
    drive(3, 6, 6, 0);
    run_chk(cyc + 1, "ill_high");
    cfg_valid = 1'b0;
    chk("err_high", 32'(cfg_err), 32'd1);
    run_chk(cyc + 1, "ill_high");
    chk("err_high_clr", 32'(cfg_err), 32'd0);
    chk("ill_ch3_ready", 32'(cfg_ready), 32'd1);
    drive(9, 4, 2, 0);
    chk("ch9_ready", 32'(cfg_ready), 32'd1);
    run_chk(cyc + 1, "ill_ch");
    cfg_valid = 1'b0;
    chk("err_ch9", 32'(cfg_err), 32'd1);
    run_chk(cyc + 1, "ill_ch");
    chk("err_ch9_clr", 32'(cfg_err), 32'd0);
    run_chk(160, "ill_after");

    // Back-pressure on ch0, then sync coincident with a wrap-apply.
    drive(0, 6, 3, 0);
    run_chk(161, "bp_wr1");
    drive(0, 8, 4, 0);
    chk("bp_ready_161", 32'(cfg_ready), 32'd0);
    run_chk(162, "bp_wait");
    chk("bp_ready_162", 32'(cfg_ready), 32'd0);
    run_chk(163, "bp_wait");
    chk("bp_ready_163", 32'(cfg_ready), 32'd0);
    set_ch(0, 164, 6, 3);
    run_chk(164, "bp_apply");
    chk("bp_ready_164", 32'(cfg_ready), 32'd1);
    run_chk(165, "bp_wr2");
    cfg_valid = 1'b0;
    chk("bp_ready_165", 32'(cfg_ready), 32'd0);
    run_chk(169, "bp_run");
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("wsync_out_low", 32'(clkout), 32'd0);
    chk("wsync_pend_clr", 32'(cfg_ready), 32'd1);
    chk("wsync_lock", 32'(LOCKED), 32'd0);
    set_all(171, 4, 2);
    set_ch(0, 171, 8, 4);
    set_ch(1, 174, 4, 2);
    set_ch(2, 171, 5, 1);
    run_chk(180, "wsync_run");

    // Asynchronous reset with a pending write on ch4.
    drive(4, 9, 2, 0);
    run_chk(181, "rst_wr");
    cfg_valid = 1'b0;
    chk("rst_pend_ready", 32'(cfg_ready), 32'd0);
    run_chk(182, "rst_wr");
    #2;
    RST = 1'b1;
    #1;
    chk("arst_clkout", 32'(clkout), 32'd0);
    chk("arst_locked", 32'(LOCKED), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    RST = 1'b0;
    cyc = 0;
    set_all(1, 4, 2);
    run_chk(8, "post_rst");
    chk("post_rst_locked", 32'(LOCKED), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clkout_div_bank.md
# clkout_div_bank

Parametrised, cycle-accurate output-divider bank clocked at VCO rate. It generates `NUM_CH` divided clock outputs, each with its own divide, high time and phase delay. Channels can be reconfigured at run time through a valid/ready write port, and a `sync` input realigns all channels. It is the next-generation replacement for the fixed seven-output divider/phase path of the PLL model, with `LOCKED` derived from configuration stability.

## Interface
- `NUM_CH`, 7, number of output channels (1–16)
- `CNT_W`, 8, width of divide/high/phase fields
- `DEF_DIV`, 4, reset divide for every channel (2 .. 2^CNT_W−1)
- `LOCK_CYCLES`, 64, clk cycles without disturbance before `LOCKED` rises
- `clk`  in  1  VCO-rate clock
- `RST`  in  1  asynchronous, active-high reset
- `sync`  in  1  one-cycle pulse; realign all channels
- `cfg_valid`  in  1  config request
- `cfg_ready`  out  1  request accepted when `cfg_valid & cfg_ready`
- `cfg_ch`  in  4  target channel
- `cfg_div`  in  CNT_W  divide value, legal ≥2
- `cfg_high`  in  CNT_W  high cycles, legal 1..cfg_div−1
- `cfg_phase`  in  CNT_W  delay in clk cycles applied at the next realign
- `cfg_err`  out  1  one-cycle pulse when an accepted request was illegal
- `clkout`  out  NUM_CH  divided outputs, registered
- `LOCKED`  out  1  all channels stable

## Operation
- Per-channel active registers: `div`, `high`, `phase`. Per-channel pending registers plus a `pend` flag. Per-channel state machine: DELAY → RUN.
- Reset values:
  - `div=DEF_DIV`, `high=DEF_DIV/2`, `phase=0`, `pend=0`.
  - `cnt=0`, state DELAY with `dly=0`.
  - `clkout=0`, `LOCKED=0`, `cfg_err=0`.
  - `cfg_ready=1`.
- DELAY state:
  - `clkout` is held low and `dly` increments.
  - When `dly==phase`, the channel enters RUN with `cnt=0`.
- RUN state:
  - `cnt` counts 0..div−1, then wraps.
  - `clkout` next = (`cnt_next < high`).
- Config write:
  - `cfg_ready = !pend[cfg_ch]`, combinational on `cfg_ch`; it is 1 for out-of-range `cfg_ch`.
  - An accepted legal request loads the pending registers and sets `pend`.
  - An illegal request (`cfg_ch ≥ NUM_CH`, `div<2`, `high==0`, `high≥div`) is accepted, dropped, and pulses `cfg_err` on the next cycle.
- Apply:
  - Pending `div`/`high` become active on the cycle the channel's `cnt` wraps (`cnt==div−1`, RUN). `pend` clears on that cycle. This is a glitch-free change at a period boundary.
  - Pending `phase` becomes active at the same point but takes effect only at the next realign.
  - A channel in DELAY applies pending values upon entering RUN.
- Realign (`sync` high):
  - All channels enter DELAY with `dly=0` on the next edge, using their active `phase`.
  - Pending values whose apply point has not occurred are applied immediately.
  - `pend` is cleared on all channels.
- `LOCKED`:
  - A counter runs from 0 up to `LOCK_CYCLES`. It resets on `RST`, `sync`, or any apply.
  - `LOCKED` = counter == `LOCK_CYCLES`. It drops the cycle after the disturbance.
- Simultaneous events:
  - `sync` has priority over a wrap-apply in the same cycle.
  - A write accepted in the same cycle as its channel's apply targets the next apply.
- Width rules:
  - All comparisons are unsigned in CNT_W.
  - `DEF_DIV/2` is truncated.
  - The lock counter width is `$clog2(LOCK_CYCLES+1)`.

## Timing
- With `phase=P`, `clkout[i]` rises on edge P+1 after `RST` deasserts or after the `sync` edge.
  - It stays high for `high` cycles and low for `div−high` cycles.
- Config latency: the new period starts at the first wrap after acceptance, at most `div_old` cycles later.
- `cfg_err`: one cycle after the acceptance edge.
- `RST` mid-operation clears everything asynchronously. Pending writes are lost.

## Structure
- Package `clkout_div_pkg`:
  - `CNT_W` default
  - channel state enum {DELAY, RUN}
  - channel config struct {div, high, phase}
  - legality function
- One sub-module `clkout_div_ch`: single-channel counter, state machine, active/pending registers and apply logic; instantiated `NUM_CH` times via generate.
- Top level: write decode, `cfg_err`, lock counter.

## Test plan
- Reset release, defaults (`DEF_DIV=4`): every `clkout` reads 1,1,0,0 repeating from edge 1; `LOCKED` rises at cycle 64.
- Write ch2 `div=5`, `high=1` mid-period: ch2 keeps the old 4-cycle period until wrap, then runs 1 high / 4 low; `LOCKED` drops and re-rises 64 cycles after the apply.
- Write ch1 `phase=3` then pulse `sync`: ch1 low for 3 cycles, high on edge 4 after `sync`; ch0 high on edge 1.
- Illegal writes (`div=1`; `high=6` with `div=6`; `cfg_ch=9` with `NUM_CH=7`): `cfg_err` pulses once each and the outputs are unchanged.
- Second write to ch0 before its wrap: `cfg_ready` is 0 until the wrap cycle and the write is accepted after it; a `sync` in the same cycle as a wrap-apply realigns and applies with `pend` cleared.
- Assert `RST` mid-period with a pending write: `clkout=0` and `LOCKED=0` immediately; after release, outputs restart with defaults.
